psum_row_drain: RTL and testbench

- Parametrised successor to the fullchip output stage.
- Captures complete core output rows (col lanes × bw_psum signed psums) into a row FIFO.
- Drains each row as a stream of narrower beats, lpb lanes per beat, over a valid/ready handshake.
- Sits between core.out and the chip-level output or testbench monitor; replaces per-cycle whole-row printing with buffered, back-pressurable readout.

---
 rtl/psum_row_drain.sv | 152 +++++++++++++++
 tb/tb_psum_row_drain.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_row_drain.sv
// -----------------------------------------------------------------------------
// psum_row_drain
//   Buffers whole core psum rows in a row FIFO and drains them as LPB-lane beats.
//   Optional macro PSUM_RELU_EN applies ReLU to every lane on the drain path.
//   Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module psum_row_drain #(
   parameter int COL     = 8,
   parameter int BW_PSUM = 20,
   parameter int DEPTH   = 4,
   parameter int LPB     = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [COL*BW_PSUM-1:0]      in_row,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [LPB*BW_PSUM-1:0]      out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last,
   output logic [$clog2(DEPTH):0]      row_count,
   output logic                        overflow
);

   localparam int c_nbeats = COL / LPB;
   localparam int c_beat_w = LPB * BW_PSUM;
   localparam int c_row_w  = COL * BW_PSUM;
   localparam int c_pw     = $clog2(DEPTH);
   localparam int c_cw     = c_pw + 1;
   localparam int c_kw     = (c_nbeats > 1) ? $clog2(c_nbeats) : 1;
   localparam logic [c_cw-1:0] c_full      = c_cw'(DEPTH);
   localparam logic [c_cw-1:0] c_one       = c_cw'(1);
   localparam logic [c_kw-1:0] c_last_beat = c_kw'(c_nbeats - 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_row_w-1:0]  r_mem [DEPTH];
   logic [c_pw-1:0]     r_wr_ptr;
   logic [c_pw-1:0]     r_rd_ptr;
   logic [c_cw-1:0]     r_count;
   logic [c_kw-1:0]     r_beat;
   logic                r_overflow;

   logic                w_push;
   logic                w_pop;
   logic                w_xfer;
   logic [c_row_w-1:0]  w_head;
   logic [c_beat_w-1:0] w_beats [c_nbeats];
   logic [c_beat_w-1:0] w_beat;
   logic [c_beat_w-1:0] w_data;

   assign in_ready  = (r_count != c_full);
   assign out_valid = (r_state == S_DRAIN);
   assign out_last  = out_valid && (r_beat == c_last_beat);
   assign row_count = r_count;
   assign overflow  = r_overflow;

   assign w_push = in_valid && in_ready;
   assign w_xfer = out_valid && out_ready;
   assign w_pop  = w_xfer && out_last;

   // Storage is deliberately not reset; validity is tracked by r_count alone.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_row;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_beat     <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_pw'(1);
         end
         if (in_valid && !in_ready) begin
            r_overflow <= 1'b1;
         end
         if (w_xfer) begin
            if (out_last) begin
               r_beat   <= '0;
               r_rd_ptr <= r_rd_ptr + c_pw'(1);
            end else begin
               r_beat <= r_beat + c_kw'(1);
            end
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_one;
            2'b01:   r_count <= r_count - c_one;
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_push) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_pop && (r_count == c_one) && !w_push) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_head = r_mem[r_rd_ptr];

   generate
      for (genvar b = 0; b < c_nbeats; b++) begin : g_beat
         assign w_beats[b] = w_head[b*c_beat_w +: c_beat_w];
      end
   endgenerate

   assign w_beat = w_beats[r_beat];

`ifdef PSUM_RELU_EN
   generate
      for (genvar l = 0; l < LPB; l++) begin : g_relu
         assign w_data[l*BW_PSUM +: BW_PSUM] =
            w_beat[l*BW_PSUM + BW_PSUM - 1] ? '0 : w_beat[l*BW_PSUM +: BW_PSUM];
      end
   endgenerate
`else
   assign w_data = w_beat;
`endif

   // Forced to zero while idle so the bus never shows stale FIFO contents.
   assign out_data = out_valid ? w_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_psum_row_drain.sv
// -----------------------------------------------------------------------------
// tb_psum_row_drain
//   Directed self-checking bench with a queue-based row FIFO reference model.
//   Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_psum_row_drain;

   localparam int COL     = 8;
   localparam int BW_PSUM = 20;
   localparam int DEPTH   = 4;
   localparam int LPB     = 2;
   localparam int NB      = COL / LPB;
   localparam int RW      = COL * BW_PSUM;
   localparam int BWID    = LPB * BW_PSUM;

   logic             clk = 1'b0;
   logic             reset;
   logic [RW-1:0]    in_row;
   logic             in_valid;
   logic             in_ready;
   logic [BWID-1:0]  out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic [$clog2(DEPTH):0] row_count;
   logic             overflow;

   int n_cmp = 0;
   int n_err = 0;

   psum_row_drain #(
      .COL(COL), .BW_PSUM(BW_PSUM), .DEPTH(DEPTH), .LPB(LPB)
   ) dut (
      .clk(clk), .reset(reset), .in_row(in_row), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .row_count(row_count),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lit(input int v);
`ifdef PSUM_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   function automatic logic [RW-1:0] pack(input int v [COL]);
      logic [RW-1:0] r;
      for (int i = 0; i < COL; i++) r[i*BW_PSUM +: BW_PSUM] = BW_PSUM'(v[i]);
      return r;
   endfunction

   function automatic logic [RW-1:0] row_seq(input int base);
      int v [COL];
      for (int i = 0; i < COL; i++) v[i] = base + i;
      return pack(v);
   endfunction

   // ---------------- reference model: queue of whole rows ----------------
   logic [RW-1:0] mq [$];
   int  mk    = 0;
   bit  movf  = 1'b0;
   int  npop  = 0;

   function automatic logic [BWID-1:0] exp_beat(input logic [RW-1:0] row, input int k);
      logic [BWID-1:0] b;
      logic signed [BW_PSUM-1:0] lane;
      for (int j = 0; j < LPB; j++) begin
         lane = row[(k*LPB + j)*BW_PSUM +: BW_PSUM];
`ifdef PSUM_RELU_EN
         if (lane < 0) lane = '0;
`endif
         b[j*BW_PSUM +: BW_PSUM] = lane;
      end
      return b;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         mk   = 0;
         movf = 1'b0;
      end else begin
         bit  full_now;
         logic [RW-1:0] pending;
         full_now = (mq.size() == DEPTH);
         pending  = in_row;
         if (in_valid && full_now) movf = 1'b1;
         if (mq.size() != 0 && out_ready) begin
            if (mk == NB - 1) begin
               mk = 0;
               void'(mq.pop_front());
               npop++;
            end else begin
               mk++;
            end
         end
         if (in_valid && !full_now) mq.push_back(pending);
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      bit v;
      v = (mq.size() != 0);
      check("cmp_valid", out_valid, v);
      check("cmp_in_ready", in_ready, mq.size() != DEPTH);
      check("cmp_count", row_count, mq.size());
      check("cmp_overflow", overflow, movf);
      check("cmp_last", out_last, v && (mk == NB - 1));
      check("cmp_data", out_data, v ? exp_beat(mq[0], mk) : '0);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check_lanes(input string name, input int l0, input int l1);
      check({name, "_l0"}, $signed(out_data[0 +: BW_PSUM]), lit(l0));
      check({name, "_l1"}, $signed(out_data[BW_PSUM +: BW_PSUM]), lit(l1));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
   endtask

   initial begin
      int exp1 [COL];
      bit done;
      int pushed;
      exp1 = '{1, -2, 3, -4, 5, -6, 7, -8};
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_row = '0;
      repeat (3) tick();
      check("rst_valid", out_valid, 0);
      check("rst_last", out_last, 0);
      check("rst_data", out_data, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_count", row_count, 0);
      check("rst_overflow", overflow, 0);
      reset = 1'b1;
      tick();

      // single row, consecutive beats
      in_row = pack(exp1); in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int b = 0; b < NB; b++) begin
         check("single_valid", out_valid, 1);
         check_lanes("single", exp1[2*b], exp1[2*b+1]);
         check("single_last", out_last, b == NB - 1);
         tick();
      end
      check("single_count_end", row_count, 0);

      // backpressure
      out_ready = 1'b0;
      in_row = pack(exp1); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         check("bp_valid", out_valid, 1);
         check_lanes("bp_hold", 1, -2);
         tick();
      end
      out_ready = 1'b1;
      for (int b = 0; b < NB; b++) begin
         check_lanes("bp_resume", exp1[2*b], exp1[2*b+1]);
         tick();
      end
      check("bp_count_end", row_count, 0);

      // full / overflow
      out_ready = 1'b0;
      for (int r = 0; r < 5; r++) begin
         in_row = row_seq((r + 1) * 10); in_valid = 1'b1;
         tick();
         if (r == 3) check("full_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      check("full_overflow", overflow, 1);
      check("full_count", row_count, 4);
      out_ready = 1'b1;
      for (int i = 0; i < 4 * NB; i++) begin
         if (i % NB == 0) check_lanes("full_row_head", (i / NB + 1) * 10, (i / NB + 1) * 10 + 1);
         tick();
      end
      check("full_drained", out_valid, 0);
      do_reset();

      // concurrent push/pop with two rows buffered
      out_ready = 1'b0;
      for (int r = 0; r < 2; r++) begin
         in_row = row_seq(100 + r * 10); in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      check("conc_pre_count", row_count, 2);
      out_ready = 1'b1;
      for (int i = 0; i < 3 * NB; i++) begin
         check("b2b_valid", out_valid, 1);
         check("b2b_last", out_last, (i % NB) == NB - 1);
         if (i == NB - 1) begin
            in_row = row_seq(120); in_valid = 1'b1;
         end
         tick();
         if (i == NB - 1) begin
            in_valid = 1'b0;
            check("conc_count", row_count, 2);
            check_lanes("conc_rowb", 110, 111);
         end
      end
      check("conc_empty", row_count, 0);

      // wrap-around with random backpressure
      pushed = 0; npop = 0; done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         out_ready = $urandom_range(0, 1);
         if (pushed < 10 && in_ready) begin
            in_row = row_seq(-40 + pushed * 9); in_valid = 1'b1; pushed++;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         done = (pushed == 10) && (npop == 10);
      end
      in_valid = 1'b0; out_ready = 1'b0;
      check("wrap_done", done, 1);
      check("wrap_overflow", overflow, 0);
      check("wrap_count", row_count, 0);

      // reset mid-drain
      out_ready = 1'b1;
      in_row = pack(exp1); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      check_lanes("mid_beat2", 5, -6);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_count", row_count, 0);
      tick();
      reset = 1'b1;
      tick();
      check("post_rst_valid", out_valid, 0);
      check("post_rst_in_ready", in_ready, 1);

      // ReLU-sensitive lanes
      begin
         int rv [COL];
         rv = '{-5, 5, 0, -1, 7, -7, 2, 3};
         out_ready = 1'b0;
         in_row = pack(rv); in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         check_lanes("relu_b0", -5, 5);
         out_ready = 1'b1;
         tick();
         check_lanes("relu_b1", 0, -1);
         repeat (NB) tick();
         check("relu_empty", row_count, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
